// File: rtl/g2b_shared_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary stage among NREQ requesters, with a registered output.
// Optional transfer counter output out_count is enabled by defining G2B_ARB_CNT_EN.
module g2b_shared_arbiter #(
    parameter int NBITS = 4,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*NBITS-1:0] req_gray,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    output logic [NBITS-1:0]      out_binary,
    output logic [IDW-1:0]        out_id,
`ifdef G2B_ARB_CNT_EN
    output logic [15:0]           out_count,
`endif
    input  logic                  out_ready
);

    // Each binary bit is the XOR of the Gray bit at that position and all bits above it.
    function automatic logic [NBITS-1:0] gray2bin(input logic [NBITS-1:0] g);
        logic [NBITS-1:0] b;
        b[NBITS-1] = g[NBITS-1];
        for (int k = NBITS - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    logic                 r_out_valid;
    logic [NBITS-1:0]     r_out_binary;
    logic [IDW-1:0]       r_out_id;
    logic [IDW-1:0]       r_rr_ptr;

    logic                 w_accept;
    logic                 w_found;
    logic [IDW-1:0]       w_win;
    logic [NBITS-1:0]     w_win_gray;
    logic [NREQ-1:0]      w_at_or_above;
    logic [IDW-1:0]       w_next_ptr;
    logic                 w_xfer;

    assign w_accept = !r_out_valid || out_ready;

    // Two passes: first the requesters at or above the pointer, then the ones below it (wrap).
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_win_gray = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_at_or_above[i] = (IDW'(i) >= r_rr_ptr);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && w_at_or_above[i]) begin
                w_found    = 1'b1;
                w_win      = IDW'(i);
                w_win_gray = req_gray[i*NBITS +: NBITS];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && !w_at_or_above[i]) begin
                w_found    = 1'b1;
                w_win      = IDW'(i);
                w_win_gray = req_gray[i*NBITS +: NBITS];
            end
        end
    end

    assign w_next_ptr = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
    assign w_xfer     = w_accept && w_found;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = resetn && w_xfer && (w_win == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid  <= 1'b0;
            r_out_binary <= '0;
            r_out_id     <= '0;
            r_rr_ptr     <= '0;
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_binary <= gray2bin(w_win_gray);
            r_out_id     <= w_win;
            r_rr_ptr     <= w_next_ptr;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

`ifdef G2B_ARB_CNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign out_count = r_count;
`endif

    assign out_valid  = r_out_valid;
    assign out_binary = r_out_binary;
    assign out_id     = r_out_id;

endmodule

// File: tb/tb_g2b_shared_arbiter.sv
// Directed bench for g2b_shared_arbiter (NBITS=4, NREQ=4); counter checks run when G2B_ARB_CNT_EN is defined.
module tb_g2b_shared_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [15:0] req_gray;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [3:0]  out_binary;
    logic [1:0]  out_id;
    logic        out_ready;
`ifdef G2B_ARB_CNT_EN
    logic [15:0] out_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    g2b_shared_arbiter #(.NBITS(4), .NREQ(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_binary (out_binary),
        .out_id     (out_id),
`ifdef G2B_ARB_CNT_EN
        .out_count  (out_count),
`endif
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    logic [3:0] conv_gray [4] = '{4'b0110, 4'b1000, 4'b1011, 4'b0001};
    logic [3:0] conv_bin  [4] = '{4'b0100, 4'b1111, 4'b1101, 4'b0001};

    initial begin
        resetn    = 1'b0;
        req_valid = 4'b1111;
        req_gray  = 16'h0000;
        out_ready = 1'b1;

        // Reset state, with requests pending to show req_ready is held low.
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_binary", 32'(out_binary), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
`ifdef G2B_ARB_CNT_EN
        chk("rst_count", 32'(out_count), 32'd0);
`endif
        step();
        resetn    = 1'b1;
        req_valid = 4'b0000;

        // Conversion from requester 2.
        req_valid = 4'b0100;
        for (int v = 0; v < 4; v++) begin
            req_gray = {4'h0, conv_gray[v], 8'h00};
            #1;
            chk($sformatf("conv_ready%0d", v), 32'(req_ready), 32'h4);
            step();
            chk($sformatf("conv_valid%0d", v), 32'(out_valid), 32'd1);
            chk($sformatf("conv_bin%0d", v), 32'(out_binary), 32'(conv_bin[v]));
            chk($sformatf("conv_id%0d", v), 32'(out_id), 32'd2);
        end
        // Drain with no winner: valid drops, data holds.
        req_valid = 4'b0000;
        step();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_hold", 32'(out_binary), 32'h1);

        // Fairness from reset.
        apply_reset();
        req_valid = 4'b1111;
        req_gray  = 16'h5A3C;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("fair_ready%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
            step();
            chk($sformatf("fair_id%0d", k), 32'(out_id), 32'(k % 4));
            chk($sformatf("fair_valid%0d", k), 32'(out_valid), 32'd1);
        end

        // Backpressure: requesters 1 and 3, consumer stalled.
        apply_reset();
        out_ready = 1'b0;
        req_valid = 4'b1010;
        req_gray  = 16'hB030;
        #1;
        chk("bp_first_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
            chk($sformatf("bp_id%0d", k), 32'(out_id), 32'd1);
            chk($sformatf("bp_bin%0d", k), 32'(out_binary), 32'h2);
            chk($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h8);
        step();
        chk("bp_next_id", 32'(out_id), 32'd3);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_bin", 32'(out_binary), 32'hD);

        // Asynchronous reset while FULL with 4'b1101.
        req_valid = 4'b0000;
        out_ready = 1'b0;
        step();
        chk("mid_full_bin", 32'(out_binary), 32'hD);
        #1;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_bin", 32'(out_binary), 32'd0);
        chk("mid_rst_id", 32'(out_id), 32'd0);
        step();
        resetn    = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        step();
        chk("post_rst_id", 32'(out_id), 32'd0);

        // Skip idle requesters; winner 3 wraps the pointer to 0.
        apply_reset();
        req_valid = 4'b1000;
        #1;
        chk("skip_ready", 32'(req_ready), 32'h8);
        step();
        chk("skip_id", 32'(out_id), 32'd3);
        req_valid = 4'b1001;
        #1;
        chk("wrap_ready", 32'(req_ready), 32'h1);
        step();
        chk("wrap_id", 32'(out_id), 32'd0);

`ifdef G2B_ARB_CNT_EN
        apply_reset();
        req_valid = 4'b0001;
        out_ready = 1'b1;
        step();
        chk("cnt_first", 32'(out_count), 32'd0);
        out_ready = 1'b0;
        repeat (3) step();
        chk("cnt_stall", 32'(out_count), 32'd0);
        out_ready = 1'b1;
        repeat (65537) step();
        chk("cnt_wrap", 32'(out_count), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/g2b_shared_arbiter.md
# g2b_shared_arbiter

Round-robin arbiter and sequencer that shares one Gray-to-binary conversion stage among `NREQ` requesters. Each requester offers a Gray-coded word with a valid/ready handshake. The block grants one requester per cycle and converts its word. It returns the binary result with the requester index through a single registered output stage with backpressure. It sits between several Gray-coded sources (counter pointers, encoder readouts) and a common binary consumer.

## Interface
- `NBITS`, default 4: width of each Gray word and binary result; minimum 1.
- `NREQ`, default 4: number of requesters; minimum 2.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  bit i set means requester i offers a word.
- `req_gray`  in  NREQ*NBITS  word of requester i at bits [i*NBITS +: NBITS].
- `req_ready`  out  NREQ  one-hot or zero; bit i set means requester i's word is taken this cycle.
- `out_valid`  out  1  the output register holds a result.
- `out_binary`  out  NBITS  the converted word.
- `out_id`  out  IDW  index of the requester that produced `out_binary`.
- `out_ready`  in  1  the consumer accepts the result this cycle.
- `out_count`  out  16  completed-transfer count; present only with `G2B_ARB_CNT_EN`.

## Operation
- Conversion: `binary[i] = ^gray[NBITS-1:i]`, so the MSB passes through and each lower bit is the XOR of itself and all higher Gray bits.
- Output register state:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- `accept = !out_valid | out_ready`.
- Arbitration is combinational:
  - Search from round-robin pointer `rr_ptr` upward, wrapping modulo `NREQ`.
  - The first i with `req_valid[i]` = 1 is the winner.
  - `req_ready[winner] = accept`; all other `req_ready` bits are 0.
- Transfer: when `accept` is 1 and a winner exists, on the clock edge:
  - load `out_binary` with the converted word and `out_id` with the winner index;
  - set `out_valid` to 1;
  - set `rr_ptr` to (winner+1) mod `NREQ`.
- Drain: `out_valid` & `out_ready` with no winner sets `out_valid` to 0. `out_binary` and `out_id` hold their last values.
- `rr_ptr` changes only on a transfer.
- While FULL and `out_ready` = 0:
  - `req_ready` is all zero;
  - `out_binary` and `out_id` stay stable.
- Requesters must keep `req_gray` stable while `req_valid` is high and `req_ready` is low. The block does not check this.

## Timing
- Reset values: `out_valid` = 0, `out_binary` = 0, `out_id` = 0, `rr_ptr` = 0, `out_count` = 0.
- `req_ready` is combinational from `req_valid`, `rr_ptr`, `out_valid` and `out_ready`. It is 0 during reset.
- Latency: a word accepted at edge N appears on `out_binary` with `out_valid` = 1 after edge N. That is 1 cycle.
- Throughput: one transfer per cycle while `out_ready` = 1.
- Simultaneous drain and load: with `out_valid` & `out_ready` and a winner present, the result register is replaced in the same edge and `out_valid` stays 1. There is no bubble.
- `out_ready` while EMPTY is ignored.
- Pointer wrap: a winner at `NREQ`-1 sets `rr_ptr` to 0.
- A single persistent requester wins every cycle.
- Reset asserted mid-operation:
  - any held result is discarded;
  - all state returns to reset values immediately, without waiting for a clock edge.
- After `resetn` deasserts, the first transfer can occur on the first rising edge.

## Configuration
- `G2B_ARB_CNT_EN` defined:
  - adds output `out_count[15:0]`;
  - increments it on every edge where `out_valid` & `out_ready` = 1;
  - wraps from 16'hFFFF to 0;
  - cleared by reset.
- `G2B_ARB_CNT_EN` undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
Defaults used throughout: `NBITS` = 4, `NREQ` = 4.
- Conversion: requester 2 sends Gray 4'b0110, then 4'b1000, 4'b1011, 4'b0001 with `out_ready` = 1 → `out_binary` reads 4'b0100, 4'b1111, 4'b1101, 4'b0001, each with `out_id` = 2, one cycle after its transfer.
- Fairness: all four `req_valid` held at 1 and `out_ready` = 1 from reset → `out_id` sequence 0,1,2,3,0,1 on consecutive cycles, and exactly one `req_ready` bit set per cycle.
- Backpressure: `out_ready` = 0 for 5 cycles with requesters 1 and 3 valid → one result with `out_id` = 1 held stable and `req_ready` = 0 for those 5 cycles. Raising `out_ready` → `out_id` = 3 on the next cycle with no bubble.
- Skip idle requesters: only requester 3 valid with `rr_ptr` = 0 → requester 3 granted immediately, and `rr_ptr` wraps to 0.
- Reset mid-operation: drop `resetn` while FULL with `out_binary` = 4'b1101 → `out_valid`, `out_binary` and `out_id` read 0 before the next edge. After release, the first grant goes to requester 0.
- With `G2B_ARB_CNT_EN`: 65537 completed transfers → `out_count` = 1. Stalled cycles (FULL and `out_ready` = 0) do not increment it.
